icache_dm: RTL and testbench

Direct-mapped, read-only instruction cache between the RISC-V core's fetch port and the instruction-side `slow_memory` inside `CHIP`. It serves 32-bit instruction words from 128-bit blocks and stalls the core on a miss. On a miss it refills one block from slow memory over the `mem_read`/`mem_ready` handshake. It never writes memory.

---
 rtl/cache_pkg.sv | 14 +
 rtl/icache_dm_if.sv | 29 ++
 rtl/icache_dm_array.sv | 44 ++++
 rtl/icache_dm.sv | 110 +++++++++++
 tb/tb_icache_dm.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared geometry and FSM state encoding for the instruction cache.
// Blocks are 128 bits, made of four 32-bit instruction words.
package cache_pkg;
    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_W        = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;
endpackage

// File: rtl/icache_dm_if.sv
// Fetch-port and slow-memory signals of the instruction cache.
// The cache uses the slave modport; the core plus memory use master.
interface icache_dm_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = 30
);
    logic                proc_read;
    logic [ADDR_W-1:0]   proc_addr;
    logic [WORD_W-1:0]   proc_rdata;
    logic                proc_stall;
    logic                flush;
    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-3:0]   mem_addr;
    logic [BLOCK_W-1:0]  mem_wdata;
    logic [BLOCK_W-1:0]  mem_rdata;
    logic                mem_ready;

    modport slave (
        input  proc_read, proc_addr, flush, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_addr, flush, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/icache_dm_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous
// write port and a synchronous clear of every valid bit.
module icache_dm_array
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = 3,
    parameter int TAG_W      = 25
) (
    input  logic               clk,
    input  logic               i_clr,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [BLOCK_W-1:0] o_rd_data,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [BLOCK_W-1:0] i_wr_data
);
    logic [NUM_BLOCKS-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

    // Clear wins over a same-edge write so a reset mid-refill leaves nothing valid.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: hit compare, refill FSM and
// deferred flush handling around the icache_dm_array storage.
module icache_dm
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 30
) (
    input  logic        clk,
    input  logic        rst,
    icache_dm_if.slave  bus
);
    localparam int IDX_W   = $clog2(NUM_BLOCKS);
    localparam int BADDR_W = ADDR_W - OFFSET_W;
    localparam int TAG_W   = BADDR_W - IDX_W;

    state_t               r_state;
    logic                 r_mem_read;
    logic [BADDR_W-1:0]   r_mem_addr;
    logic                 r_flush_pend;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_line_valid;
    logic [TAG_W-1:0]     w_line_tag;
    logic [BLOCK_W-1:0]   w_line_data;
    logic [WORD_W-1:0]    w_words [WORDS_PER_BLOCK];
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_idle;
    logic                 w_clr;
    logic                 w_wr_en;

    assign w_idx  = bus.proc_addr[OFFSET_W +: IDX_W];
    assign w_tag  = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign w_hit  = bus.proc_read && w_line_valid && (w_line_tag == w_tag);
    assign w_miss = bus.proc_read && !w_hit;
    assign w_idle = (r_state == IDLE);

    // A flush seen in FETCH/FILL lands here only after the retried access is served.
    assign w_clr   = rst || (w_idle && (bus.flush || r_flush_pend));
    assign w_wr_en = (r_state == FETCH) && bus.mem_ready && !rst;

    icache_dm_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk        (clk),
        .i_clr      (w_clr),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_mem_addr[IDX_W-1:0]),
        .i_wr_tag   (r_mem_addr[BADDR_W-1 -: TAG_W]),
        .i_wr_data  (bus.mem_rdata)
    );

    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
        assign w_words[gi] = w_line_data[WORD_W*gi +: WORD_W];
    end

    assign bus.proc_rdata = w_hit ? w_words[bus.proc_addr[OFFSET_W-1:0]] : '0;
    assign bus.proc_stall = !w_idle || w_miss;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_write  = 1'b0;
    assign bus.mem_wdata  = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mem_read   <= 1'b0;
            r_mem_addr   <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_flush_pend <= 1'b0;
                    if (w_miss) begin
                        r_mem_addr <= bus.proc_addr[ADDR_W-1:OFFSET_W];
                        r_mem_read <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (bus.mem_ready) begin
                        r_mem_read <= 1'b0;
                        r_state    <= FILL;
                    end
                end
                FILL: begin
                    if (bus.flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_read <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a latency-10 slow-memory model and one task
// per scenario, each checking stall length, refill address and returned word.
module tb_icache_dm;
    localparam int ADDR_W = 30;
    localparam int LAT    = 10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   mem_auto;
    int   mem_cnt;

    icache_dm_if #(.ADDR_W(ADDR_W)) bus ();

    icache_dm #(.NUM_BLOCKS(8), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] blk(input logic [27:0] a);
        logic [127:0] b;
        if (a == 28'd1) begin
            b = 128'h44444444_33333333_22222222_11111111;
        end else begin
            for (int w = 0; w < 4; w++) begin
                b[32*w +: 32] = 32'hC0DE0000 | {16'h0000, a[7:0], 8'(w)};
            end
        end
        return b;
    endfunction

    // Slow-memory model: mem_ready pulses in the LAT-th cycle of mem_read.
    initial begin
        mem_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                if (bus.mem_read && !rst) begin
                    mem_cnt = mem_cnt + 1;
                    if (mem_cnt == LAT) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = blk(bus.mem_addr);
                        mem_cnt = 0;
                    end else begin
                        bus.mem_ready = 1'b0;
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                    mem_cnt = 0;
                end
            end
        end
    end

    // Issues one fetch and waits (bounded) until it completes; no checking here.
    task automatic do_read(input logic [29:0] addr, output int stalls,
                           output logic [31:0] data, output logic [27:0] maddr,
                           output int mr_cycles, output bit maddr_moved,
                           output bit timeout);
        bit seen;
        stalls = 0; data = '0; maddr = '0; mr_cycles = 0;
        maddr_moved = 0; timeout = 0; seen = 0;
        bus.proc_read = 1'b1;
        bus.proc_addr = addr;
        forever begin
            @(negedge clk);
            if (bus.mem_read) begin
                mr_cycles++;
                if (!seen) begin
                    maddr = bus.mem_addr;
                    seen = 1;
                end else if (bus.mem_addr !== maddr) begin
                    maddr_moved = 1;
                end
            end
            if (!bus.proc_stall) begin
                data = bus.proc_rdata;
                break;
            end
            stalls++;
            if (stalls > 200) begin
                timeout = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.proc_read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks += 6;
        if (bus.proc_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.proc_stall); end
        if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %b want 0", bus.mem_read); end
        if (bus.mem_addr !== 28'd0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        if (bus.proc_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.proc_rdata); end
        if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %b want 0", bus.mem_write); end
        if (bus.mem_wdata !== 128'd0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
        $display("reset: stall=%b mem_read=%b mem_addr=%h", bus.proc_stall, bus.mem_read, bus.mem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_cold_miss();
        int st, mr; logic [31:0] d; logic [27:0] ma; bit mv, to;
        do_read(30'h5, st, d, ma, mr, mv, to);
        $display("cold_miss addr=0x5 stalls=%0d data=%h mem_addr=%h mem_read_cycles=%0d", st, d, ma, mr);
        n_checks += 6;
        if (to) begin n_fail++; $display("FAIL cold_timeout got timeout want completion"); end
        if (st != 12) begin n_fail++; $display("FAIL cold_stalls got %0d want 12", st); end
        if (d !== 32'h22222222) begin n_fail++; $display("FAIL cold_data got %h want 22222222", d); end
        if (ma !== 28'd1) begin n_fail++; $display("FAIL cold_mem_addr got %h want 1", ma); end
        if (mr != 10) begin n_fail++; $display("FAIL cold_mem_read_cycles got %0d want 10", mr); end
        if (mv) begin n_fail++; $display("FAIL cold_mem_addr_held got moved want stable"); end
    endtask

    task automatic test_back_to_back();
        logic [29:0] addrs [3];
        logic [31:0] exp   [3];
        int st, mr; logic [31:0] d; logic [27:0] ma; bit mv, to;
        addrs[0] = 30'h4; exp[0] = 32'h11111111;
        addrs[1] = 30'h6; exp[1] = 32'h33333333;
        addrs[2] = 30'h7; exp[2] = 32'h44444444;
        for (int i = 0; i < 3; i++) begin
            do_read(addrs[i], st, d, ma, mr, mv, to);
            $display("hit addr=%h stalls=%0d data=%h", addrs[i], st, d);
            n_checks += 2;
            if (st != 0) begin n_fail++; $display("FAIL hit_stalls addr=%h got %0d want 0", addrs[i], st); end
            if (d !== exp[i]) begin n_fail++; $display("FAIL hit_data addr=%h got %h want %h", addrs[i], d, exp[i]); end
        end
    endtask

    task automatic test_conflict();
        int st, mr; logic [31:0] d; logic [27:0] ma; bit mv, to;
        do_read(30'h25, st, d, ma, mr, mv, to);
        $display("conflict addr=0x25 stalls=%0d data=%h mem_addr=%h", st, d, ma);
        n_checks += 3;
        if (st != 12) begin n_fail++; $display("FAIL conflict_stalls got %0d want 12", st); end
        if (ma !== 28'd9) begin n_fail++; $display("FAIL conflict_mem_addr got %h want 9", ma); end
        if (d !== 32'hC0DE0901) begin n_fail++; $display("FAIL conflict_data got %h want c0de0901", d); end
        do_read(30'h5, st, d, ma, mr, mv, to);
        $display("conflict reread addr=0x5 stalls=%0d data=%h mem_addr=%h", st, d, ma);
        n_checks += 2;
        if (st != 12) begin n_fail++; $display("FAIL conflict_reread_stalls got %0d want 12", st); end
        if (d !== 32'h22222222) begin n_fail++; $display("FAIL conflict_reread_data got %h want 22222222", d); end
    endtask

    task automatic test_flush_idle();
        int st, mr; logic [31:0] d; logic [27:0] ma; bit mv, to;
        // Flush and a hit in the same cycle: lookup still sees the old line.
        bus.flush = 1'b1;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h5;
        @(negedge clk);
        $display("flush_same_cycle addr=0x5 stall=%b data=%h", bus.proc_stall, bus.proc_rdata);
        n_checks += 2;
        if (bus.proc_stall !== 1'b0) begin n_fail++; $display("FAIL flush_same_stall got %b want 0", bus.proc_stall); end
        if (bus.proc_rdata !== 32'h22222222) begin n_fail++; $display("FAIL flush_same_data got %h want 22222222", bus.proc_rdata); end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.proc_read = 1'b0;
        do_read(30'h5, st, d, ma, mr, mv, to);
        $display("flush_idle reread addr=0x5 stalls=%0d data=%h", st, d);
        n_checks += 2;
        if (st != 12) begin n_fail++; $display("FAIL flush_idle_stalls got %0d want 12", st); end
        if (d !== 32'h22222222) begin n_fail++; $display("FAIL flush_idle_data got %h want 22222222", d); end
    endtask

    task automatic test_flush_fetch();
        int st, mr; logic [31:0] d; logic [27:0] ma; bit mv, to;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.flush = 1'b1;
                @(posedge clk);
                #1;
                bus.flush = 1'b0;
            end
        join_none
        do_read(30'h2, st, d, ma, mr, mv, to);
        $display("flush_fetch addr=0x2 stalls=%0d data=%h mem_addr=%h", st, d, ma);
        n_checks += 3;
        if (st != 12) begin n_fail++; $display("FAIL flush_fetch_stalls got %0d want 12", st); end
        if (d !== 32'hC0DE0002) begin n_fail++; $display("FAIL flush_fetch_data got %h want c0de0002", d); end
        if (ma !== 28'd0) begin n_fail++; $display("FAIL flush_fetch_mem_addr got %h want 0", ma); end
        do_read(30'h3, st, d, ma, mr, mv, to);
        $display("flush_fetch next addr=0x3 stalls=%0d data=%h", st, d);
        n_checks += 2;
        if (st != 12) begin n_fail++; $display("FAIL flush_fetch_next_stalls got %0d want 12", st); end
        if (d !== 32'hC0DE0003) begin n_fail++; $display("FAIL flush_fetch_next_data got %h want c0de0003", d); end
    endtask

    task automatic test_reset_mid_refill();
        int st, mr; logic [31:0] d; logic [27:0] ma; bit mv, to;
        mem_auto = 1'b0;
        bus.mem_ready = 1'b0;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h11;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks += 1;
        if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL rst_mid_fetch_mem_read got %b want 1", bus.mem_read); end
        rst = 1'b1;
        bus.proc_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        $display("reset_mid_refill: mem_read=%b stall=%b", bus.mem_read, bus.proc_stall);
        n_checks += 2;
        if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_read got %b want 0", bus.mem_read); end
        if (bus.proc_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got %b want 0", bus.proc_stall); end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = blk(28'h4);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_checks += 1;
        if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL late_ready_mem_read got %b want 0", bus.mem_read); end
        @(posedge clk);
        #1;
        mem_auto = 1'b1;
        do_read(30'h10, st, d, ma, mr, mv, to);
        $display("after reset addr=0x10 stalls=%0d data=%h", st, d);
        n_checks += 2;
        if (st != 12) begin n_fail++; $display("FAIL late_ready_ignored_stalls got %0d want 12", st); end
        if (d !== 32'hC0DE0400) begin n_fail++; $display("FAIL late_ready_ignored_data got %h want c0de0400", d); end
        do_read(30'h3, st, d, ma, mr, mv, to);
        $display("after reset addr=0x3 stalls=%0d data=%h", st, d);
        n_checks += 1;
        if (st != 12) begin n_fail++; $display("FAIL rst_invalidated_stalls got %0d want 12", st); end
    endtask

    task automatic test_idle_core();
        int bad;
        bad = 0;
        bus.proc_read = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (bus.proc_stall !== 1'b0) begin n_fail++; bad++; $display("FAIL idle_stall cycle=%0d got %b want 0", i, bus.proc_stall); end
            if (bus.mem_read !== 1'b0) begin n_fail++; bad++; $display("FAIL idle_mem_read cycle=%0d got %b want 0", i, bus.mem_read); end
        end
        $display("idle_core: 20 cycles, %0d bad samples", bad);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        mem_auto = 1'b1;
        rst = 1'b1;
        bus.proc_read = 1'b0;
        bus.proc_addr = '0;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush_idle();
        test_flush_fetch();
        test_reset_mid_refill();
        test_idle_core();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
